cla_bist_checker: RTL and testbench

CLA_BIST_CHECKER -- requirements
Module: cla_bist_checker

---
 rtl/cla_bist_pkg.sv | 22 ++
 rtl/cla_ref_model.sv | 40 ++++
 rtl/cla_bist_checker.sv | 152 +++++++++++++++
 tb/tb_cla_bist_checker.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_bist_pkg.sv
// Package shared by the CLA built-in self-test checker and its reference model.
// Contents:
//   state_t     - checker FSM states (IDLE, APPLY, CHECK, DONE)
//   NUM_VECTORS - number of exhaustive {A,B,Cin} vectors (512)
//   VEC_W       - width of the vector index (9)
//   ERR_W       - width of the error counter (10, so 512 fits without saturating)
//   DATA_W      - operand width of the CLA under test (4)
package cla_bist_pkg;

  localparam int NUM_VECTORS = 512;
  localparam int VEC_W       = 9;
  localparam int ERR_W       = 10;
  localparam int DATA_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cla_ref_model.sv
// Combinational golden model of a 4-bit carry-lookahead adder.
// Ports:
//   a, b  in  DATA_W  operands
//   cin   in  1       carry-in
//   s     out DATA_W  expected sum (a+b+cin)[3:0]
//   cout  out 1       expected carry-out (a+b+cin)[4]
//   g     out DATA_W  expected generate vector a&b
//   p     out DATA_W  expected propagate vector a^b
module cla_ref_model
  import cla_bist_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] s,
  output logic              cout,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] p
);

  logic [DATA_W:0] total;

  // The sum is taken from a plain wide addition rather than a carry chain,
  // so the reference does not share structure with the adder it judges.
  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
  end

  assign s    = total[DATA_W-1:0];
  assign cout = total[DATA_W];

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : gen_gp
      assign g[gi] = a[gi] & b[gi];
      assign p[gi] = a[gi] ^ b[gi];
    end
  endgenerate

endmodule

// File: rtl/cla_bist_checker.sv
// Exhaustive self-test sequencer and checker for an external 4-bit CLA.
// Sweeps every {A,B,Cin} combination in ascending order, two cycles per
// vector (APPLY then CHECK), and compares the CLA's S, Cout, G and P
// against cla_ref_model.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          in  1   request a full run (accepted in IDLE/DONE only)
//   A, B, Cin      out     registered stimulus to the CLA under test
//   G, P, S, Cout  in      responses from the CLA under test
//   busy           out 1   run in progress (APPLY or CHECK)
//   done           out 1   run finished, held until start or reset
//   pass           out 1   with done: no failing vector
//   err_cnt        out 10  failing vectors in current/last run
//   fail_valid     out 1   at least one vector failed
//   first_fail     out 9   {A,B,Cin} of the first failing vector
module cla_bist_checker
  import cla_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              Cin,
  input  logic [DATA_W-1:0] G,
  input  logic [DATA_W-1:0] P,
  input  logic [DATA_W-1:0] S,
  input  logic              Cout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              fail_valid,
  output logic [VEC_W-1:0]  first_fail
);

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [VEC_W-1:0]   vec_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;
  logic               cin_reg;
  logic [ERR_W-1:0]   err_cnt_reg;
  logic               fail_valid_reg;
  logic [VEC_W-1:0]   first_fail_reg;

  logic [DATA_W-1:0]  exp_s;
  logic               exp_cout;
  logic [DATA_W-1:0]  exp_g;
  logic [DATA_W-1:0]  exp_p;
  logic               mismatch;
  logic               last_vec;

  // Expected values are formed from the registered operands, i.e. exactly
  // what the CLA has been seeing since the APPLY edge.
  cla_ref_model u_ref (
    .a    (a_reg),
    .b    (b_reg),
    .cin  (cin_reg),
    .s    (exp_s),
    .cout (exp_cout),
    .g    (exp_g),
    .p    (exp_p)
  );

  assign mismatch = (S != exp_s) || (Cout != exp_cout) ||
                    (G != exp_g) || (P != exp_p);
  assign last_vec = (vec_reg == LAST_VEC);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = APPLY;
      APPLY:      state_next = CHECK;
      CHECK:      state_next = last_vec ? DONE : APPLY;
      default:    state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // pass is derived from DONE, so it changes on the same edge as done and
  // always reflects the final error count including the last vector.
  always_comb begin
    busy = (state_reg == APPLY) || (state_reg == CHECK);
    done = (state_reg == DONE);
    pass = (state_reg == DONE) && (err_cnt_reg == '0);
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_reg        <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      cin_reg        <= 1'b0;
      err_cnt_reg    <= '0;
      fail_valid_reg <= 1'b0;
      first_fail_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            vec_reg        <= '0;
            err_cnt_reg    <= '0;
            fail_valid_reg <= 1'b0;
            first_fail_reg <= '0;
          end
        end
        APPLY: begin
          // Operands are held through the following CHECK cycle, giving the
          // combinational CLA a full cycle to settle before comparison.
          a_reg   <= vec_reg[VEC_W-1 -: DATA_W];
          b_reg   <= vec_reg[DATA_W:1];
          cin_reg <= vec_reg[0];
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
            if (!fail_valid_reg) begin
              fail_valid_reg <= 1'b1;
              first_fail_reg <= vec_reg;
            end
          end
          if (!last_vec) begin
            vec_reg <= vec_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign A          = a_reg;
  assign B          = b_reg;
  assign Cin        = cin_reg;
  assign err_cnt    = err_cnt_reg;
  assign fail_valid = fail_valid_reg;
  assign first_fail = first_fail_reg;

endmodule

// File: tb/tb_cla_bist_checker.sv
// Directed testbench for cla_bist_checker. Provides a behavioural 4-bit
// adder as the CLA under test, with selectable stuck-at faults.
module tb_cla_bist_checker;
  import cla_bist_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              Cin;
  logic [DATA_W-1:0] G;
  logic [DATA_W-1:0] P;
  logic [DATA_W-1:0] S;
  logic              Cout;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic              fail_valid;
  logic [VEC_W-1:0]  first_fail;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int fault_mode = 0;  // 0: good, 1: S[0] stuck 0, 2: Cout stuck 0

  cla_bist_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .Cin        (Cin),
    .G          (G),
    .P          (P),
    .S          (S),
    .Cout       (Cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .first_fail (first_fail)
  );

  // CLA under test (behavioural) with fault injection.
  logic [4:0] cla_tot;
  always_comb begin
    cla_tot = {1'b0, A} + {1'b0, B} + {4'b0, Cin};
    S    = cla_tot[3:0];
    Cout = cla_tot[4];
    G    = A & B;
    P    = A ^ B;
    if (fault_mode == 1) S[0] = 1'b0;
    if (fault_mode == 2) Cout = 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start sampled at the next rising edge (edge 0); returns #1 after it.
  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after edge 0 until done, bounded.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!done && n < 1100) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;
  int bn;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fv", fail_valid, 0);
    check("rst_ff", first_fail, 0);
    check("rst_ops", {A, B, Cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Correct CLA
    fault_mode = 0;
    start_pulse();
    check("good_busy0", busy, 1);
    wait_done(n, bn);
    check("good_latency", n, 1024);
    check("good_busy_cycles", bn, 1024);
    check("good_busy_end", busy, 0);
    check("good_done", done, 1);
    check("good_pass", pass, 1);
    check("good_err", err_cnt, 0);
    check("good_fv", fail_valid, 0);
    $display("run good: cycles=%0d err_cnt=%0d pass=%0b", n, err_cnt, pass);

    // S[0] stuck at 0
    fault_mode = 1;
    start_pulse();
    wait_done(n, bn);
    check("s0_latency", n, 1024);
    check("s0_err", err_cnt, 256);
    check("s0_ff", first_fail, 9'h001);
    check("s0_fv", fail_valid, 1);
    check("s0_pass", pass, 0);
    repeat (5) @(posedge clk);
    #1;
    check("s0_hold_done", done, 1);
    check("s0_hold_err", err_cnt, 256);
    $display("run s0_stuck: cycles=%0d err_cnt=%0d first_fail=%03h", n, err_cnt, first_fail);

    // Cout stuck at 0
    fault_mode = 2;
    start_pulse();
    wait_done(n, bn);
    check("co_err", err_cnt, 256);
    check("co_ff", first_fail, 9'h01F);
    check("co_pass", pass, 0);
    $display("run cout_stuck: cycles=%0d err_cnt=%0d first_fail=%03h", n, err_cnt, first_fail);

    // Restart from DONE after a failed run
    fault_mode = 0;
    start_pulse();
    check("rs_err_clr", err_cnt, 0);
    check("rs_fv_clr", fail_valid, 0);
    check("rs_done_clr", done, 0);
    check("rs_busy", busy, 1);
    wait_done(n, bn);
    check("rs_latency", n, 1024);
    check("rs_pass", pass, 1);
    $display("run restart: cycles=%0d pass=%0b", n, pass);

    // Reset in the middle of a faulty run
    fault_mode = 1;
    start_pulse();
    repeat (299) @(posedge clk);
    #1;
    check("mid_err_nonzero", err_cnt != 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_pass", pass, 0);
    check("ar_err", err_cnt, 0);
    check("ar_fv", fail_valid, 0);
    check("ar_ff", first_fail, 0);
    check("ar_ops", {A, B, Cin}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ar_stay_idle", {busy, done}, 0);
    fault_mode = 0;
    start_pulse();
    wait_done(n, bn);
    check("ar_latency", n, 1024);
    check("ar_pass", pass, 1);
    $display("run after_reset: cycles=%0d pass=%0b", n, pass);

    // Start during a run is ignored
    start_pulse();
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      start = (i == 100);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (i == 1023) check("ign_done_early", done, 0);
    end
    check("ign_done", done, 1);
    check("ign_busy", busy, 0);
    check("ign_pass", pass, 1);
    $display("run ignore_start: done=%0b pass=%0b", done, pass);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
